// File: rtl/prio_grant_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prio_grant_if                                                              |
// | Request / grant handshake bundle between N requesters and prio_grant_enc.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface prio_grant_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  req;
    logic          grant_ack;
    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    logic [N-1:0]  grant_oh;
    logic          req_any;

    modport master (
        output req,
        output grant_ack,
        input  grant_vld,
        input  grant_idx,
        input  grant_oh,
        input  req_any
    );

    modport slave (
        input  req,
        input  grant_ack,
        output grant_vld,
        output grant_idx,
        output grant_oh,
        output req_any
    );
endinterface
`default_nettype wire

// File: rtl/prio_grant_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prio_grant_enc                                                             |
// | Registered N-input priority encoder with a grant held until acknowledged.  |
// | Fixed highest-index-first priority; rotating priority when                 |
// | PRIO_GRANT_ROUND_ROBIN_EN is defined.                                      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module prio_grant_enc #(
    parameter int N = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    prio_grant_if.slave bus
);
    localparam int IW = $clog2(N);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]    r_state;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_oh;

    logic          w_req_any;
    logic          w_arb;
    logic [IW-1:0] w_win_idx;
    logic [N-1:0]  w_win_oh;

    assign w_req_any = |bus.req;

    // Arbitration happens from IDLE, or from HOLD on the accepting edge.
    assign w_arb = (r_state == S_IDLE) || bus.grant_ack;

`ifdef PRIO_GRANT_ROUND_ROBIN_EN
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic          w_found;

    function automatic logic [IW-1:0] rr_slot(input logic [IW-1:0] p, input int i);
        int s;
        s = int'(p) - i;
        if (s < 0) begin
            s = s + N;
        end
        return IW'(s);
    endfunction

    // Scan downward from the pointer with wrap; the first set bit wins.
    always_comb begin
        w_win_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && bus.req[rr_slot(r_ptr, i)]) begin
                w_win_idx = rr_slot(r_ptr, i);
                w_found   = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (w_win_idx == '0) ? IW'(N - 1) : (w_win_idx - IW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(N - 1);
        end else if (w_arb && w_req_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
                w_win_idx = IW'(i);
            end
        end
    end
`endif

    assign w_win_oh = N'(1) << w_win_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_oh    <= '0;
        end else if (w_arb) begin
            if (w_req_any) begin
                r_state <= S_HOLD;
                r_idx   <= w_win_idx;
                r_oh    <= w_win_oh;
            end else begin
                r_state <= S_IDLE;
                r_idx   <= '0;
                r_oh    <= '0;
            end
        end
    end

    assign bus.grant_vld = (r_state == S_HOLD);
    assign bus.grant_idx = r_idx;
    assign bus.grant_oh  = r_oh;
    assign bus.req_any   = w_req_any;

endmodule
`default_nettype wire

// File: tb/tb_prio_grant_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prio_grant_enc                                                          |
// | Self-checking bench for prio_grant_enc at N=4 and N=8 against a            |
// | behavioural model; follows PRIO_GRANT_ROUND_ROBIN_EN like the design.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_prio_grant_enc;
    logic clk = 1'b0;
    logic rst4_n;
    logic rst8_n;
    int   checks = 0;
    int   errors = 0;

    prio_grant_if #(.N(4)) if4 ();
    prio_grant_if #(.N(8)) if8 ();

    prio_grant_enc #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst4_n), .bus(if4.slave));
    prio_grant_enc #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst8_n), .bus(if8.slave));

    always #5 clk = ~clk;

    logic m4_v, m8_v;
    int   m4_idx, m8_idx, m4_ptr, m8_ptr;

    // Winner for request vector r among n requesters with pointer p; -1 if none.
    function automatic int pick(input logic [7:0] r, input int n, input int p);
`ifdef PRIO_GRANT_ROUND_ROBIN_EN
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p - k + n) % n;
            if (r[c]) return c;
        end
`else
        for (int c = n - 1; c >= 0; c--) begin
            if (r[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic mstep(input int n, input logic [7:0] r, input logic a,
                         inout logic v, inout int idx, inout int p);
        int k;
        if (!v || a) begin
            k = pick(r, n, p);
            if (k >= 0) begin
                v   = 1'b1;
                idx = k;
                p   = (k + n - 1) % n;
            end else begin
                v   = 1'b0;
                idx = 0;
            end
        end
    endtask

    task automatic mreset4();
        m4_v = 1'b0; m4_idx = 0; m4_ptr = 3;
    endtask

    task automatic mreset8();
        m8_v = 1'b0; m8_idx = 0; m8_ptr = 7;
    endtask

    function automatic logic [6:0] exp4();
        return {m4_v, 2'(m4_idx), m4_v ? 4'(1 << m4_idx) : 4'b0};
    endfunction

    function automatic logic [11:0] exp8();
        return {m8_v, 3'(m8_idx), m8_v ? 8'(1 << m8_idx) : 8'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst4_n) mstep(4, {4'b0, if4.req}, if4.grant_ack, m4_v, m4_idx, m4_ptr);
        if (rst8_n) mstep(8, if8.req, if8.grant_ack, m8_v, m8_idx, m8_ptr);
        #1;
    endtask

    task automatic test_reset();
        rst4_n = 1'b0; rst8_n = 1'b0;
        if4.req = '0; if4.grant_ack = 1'b0;
        if8.req = '0; if8.grant_ack = 1'b0;
        mreset4(); mreset8();
        @(posedge clk); #1;
        checks++;
        if ({if4.grant_vld, if4.grant_idx, if4.grant_oh, if4.req_any} !== 8'b0) begin
            errors++;
            $display("FAIL reset4 got %b want 0", {if4.grant_vld, if4.grant_idx, if4.grant_oh, if4.req_any});
        end
        checks++;
        if ({if8.grant_vld, if8.grant_idx, if8.grant_oh, if8.req_any} !== 13'b0) begin
            errors++;
            $display("FAIL reset8 got %b want 0", {if8.grant_vld, if8.grant_idx, if8.grant_oh, if8.req_any});
        end
        @(negedge clk);
        rst4_n = 1'b1; rst8_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({if4.grant_vld, if4.req_any} !== 2'b00) begin
                errors++;
                $display("FAIL idle cyc %0d vld/req_any got %b want 00", i, {if4.grant_vld, if4.req_any});
            end
        end
    endtask

    task automatic test_sweep();
        logic [3:0] r;
        logic [1:0] li;
        if4.grant_ack = 1'b1;
        for (int v = 0; v < 16; v++) begin
            r = 4'(v);
            if4.req = r;
            tick();
            checks++;
            if ({if4.grant_vld, if4.grant_idx, if4.grant_oh} !== exp4()) begin
                errors++;
                $display("FAIL sweep req=%b got %b want %b", r, {if4.grant_vld, if4.grant_idx, if4.grant_oh}, exp4());
            end
`ifndef PRIO_GRANT_ROUND_ROBIN_EN
            li = r[3] ? 2'd3 : r[2] ? 2'd2 : r[1] ? 2'd1 : 2'd0;
            checks++;
            if ({if4.grant_vld, if4.grant_idx} !== {(r != 4'b0), li}) begin
                errors++;
                $display("FAIL legacy req=%b got %b want %b", r, {if4.grant_vld, if4.grant_idx}, {(r != 4'b0), li});
            end
`endif
        end
        if4.req = '0;
        tick();
    endtask

    task automatic test_hold();
        if4.req = '0; if4.grant_ack = 1'b1;
        tick();
        if4.req = 4'b0100; if4.grant_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if4.req = 4'b0000;
            checks++;
            if ({if4.grant_vld, if4.grant_idx, if4.grant_oh} !== 7'b1_10_0100) begin
                errors++;
                $display("FAIL hold cyc %0d got %b want 1100100", i, {if4.grant_vld, if4.grant_idx, if4.grant_oh});
            end
        end
        if4.grant_ack = 1'b1;
        tick();
        checks++;
        if ({if4.grant_vld, if4.grant_idx, if4.grant_oh} !== 7'b0) begin
            errors++;
            $display("FAIL hold_release got %b want 0", {if4.grant_vld, if4.grant_idx, if4.grant_oh});
        end
    endtask

`ifndef PRIO_GRANT_ROUND_ROBIN_EN
    task automatic test_back_to_back();
        if4.req = 4'b1010; if4.grant_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({if4.grant_vld, if4.grant_idx} !== 3'b1_11) begin
                errors++;
                $display("FAIL b2b cyc %0d got %b want 111", i, {if4.grant_vld, if4.grant_idx});
            end
        end
        if4.req = 4'b0010;
        tick();
        checks++;
        if ({if4.grant_vld, if4.grant_idx, if4.grant_oh} !== 7'b1_01_0010) begin
            errors++;
            $display("FAIL b2b_switch got %b want 1010010", {if4.grant_vld, if4.grant_idx, if4.grant_oh});
        end
        if4.req = '0;
        tick();
    endtask
`else
    task automatic test_round_robin();
        int seq_a [5] = '{3, 2, 1, 0, 3};
        int seq_b [4] = '{3, 0, 3, 0};
        @(negedge clk); rst4_n = 1'b0; mreset4();
        #1 rst4_n = 1'b1;
        if4.req = 4'b1111; if4.grant_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({if4.grant_vld, if4.grant_idx} !== {1'b1, 2'(seq_a[i])}) begin
                errors++;
                $display("FAIL rr_all step %0d got %b want idx %0d", i, {if4.grant_vld, if4.grant_idx}, seq_a[i]);
            end
        end
        @(negedge clk); rst4_n = 1'b0; mreset4();
        #1 rst4_n = 1'b1;
        if4.req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({if4.grant_vld, if4.grant_idx} !== {1'b1, 2'(seq_b[i])}) begin
                errors++;
                $display("FAIL rr_pair step %0d got %b want idx %0d", i, {if4.grant_vld, if4.grant_idx}, seq_b[i]);
            end
        end
        if4.req = '0;
        tick();
    endtask
`endif

    task automatic test_async_reset();
        if8.req = '0; if8.grant_ack = 1'b1;
        tick();
        if8.req = 8'h20; if8.grant_ack = 1'b0;
        tick();
        checks++;
        if ({if8.grant_vld, if8.grant_idx, if8.grant_oh} !== 12'b1_101_00100000) begin
            errors++;
            $display("FAIL areset_pre got %b want 110100100000", {if8.grant_vld, if8.grant_idx, if8.grant_oh});
        end
        #2 rst8_n = 1'b0;
        mreset8();
        #1;
        checks++;
        if ({if8.grant_vld, if8.grant_idx, if8.grant_oh} !== 12'b0) begin
            errors++;
            $display("FAIL areset_clear got %b want 0", {if8.grant_vld, if8.grant_idx, if8.grant_oh});
        end
        #2 rst8_n = 1'b1;
        if8.req = 8'h81; if8.grant_ack = 1'b1;
        tick();
        checks++;
        if ({if8.grant_vld, if8.grant_idx, if8.grant_oh} !== 12'b1_111_10000000) begin
            errors++;
            $display("FAIL areset_ptr got %b want 111110000000", {if8.grant_vld, if8.grant_idx, if8.grant_oh});
        end
        if8.req = '0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if4.req       = 4'($urandom_range(0, 15));
            if4.grant_ack = 1'($urandom_range(0, 1));
            if8.req       = 8'($urandom_range(0, 255)) & (($urandom_range(0, 3) == 0) ? 8'h00 : 8'hFF);
            if8.grant_ack = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({if4.req_any, if8.req_any} !== {(if4.req != 4'b0), (if8.req != 8'b0)}) begin
                errors++;
                $display("FAIL rand_req_any cyc %0d got %b want %b", i, {if4.req_any, if8.req_any},
                         {(if4.req != 4'b0), (if8.req != 8'b0)});
            end
            tick();
            checks++;
            if ({if4.grant_vld, if4.grant_idx, if4.grant_oh} !== exp4()) begin
                errors++;
                $display("FAIL rand4 cyc %0d got %b want %b", i, {if4.grant_vld, if4.grant_idx, if4.grant_oh}, exp4());
            end
            checks++;
            if ({if8.grant_vld, if8.grant_idx, if8.grant_oh} !== exp8()) begin
                errors++;
                $display("FAIL rand8 cyc %0d got %b want %b", i, {if8.grant_vld, if8.grant_idx, if8.grant_oh}, exp8());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_hold();
`ifndef PRIO_GRANT_ROUND_ROBIN_EN
        test_back_to_back();
`else
        test_round_robin();
`endif
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
